cam_stream_packer: RTL

//  Parametrised successor camera front end. Samples a BUS_W-bit camera bus on pclk and packs

---
 rtl/cam_pkg.sv | 25 ++
 rtl/cam_delta_coder.sv | 50 +++++
 rtl/cam_stream_packer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/cam_pkg.sv
// cam_pkg: mode codes, FSM encoding and status-word layout shared by the camera packer
package cam_pkg;
    localparam logic [2:0] MODE_RAW   = 3'b000;
    localparam logic [2:0] MODE_DEC   = 3'b100;
    localparam logic [2:0] MODE_DELTA = 3'b111;
    typedef enum logic [2:0] {
        S_IDLE, S_HEADER, S_ACTIVE, S_FLUSH, S_TRAIL_END, S_TRAIL_STAT
    } state_t;
    localparam int ST_CNT_LSB  = 0;
    localparam int ST_MODE_LSB = 4;
    localparam int ST_OVF_BIT  = 7;
    function automatic logic [7:0] status_word(input logic ovf, input logic [2:0] mode,
                                               input logic [3:0] cnt);
        logic [7:0] s;
        s = '0;
        s[ST_OVF_BIT] = ovf;
        s[ST_MODE_LSB +: 3] = mode;
        s[ST_CNT_LSB +: 4] = cnt;
        return s;
    endfunction
    // unknown commands fall back to raw and report as raw
    function automatic logic [2:0] norm_mode(input logic [2:0] cmd);
        return (cmd == MODE_DEC || cmd == MODE_DELTA) ? cmd : MODE_RAW;
    endfunction
endpackage

// File: rtl/cam_delta_coder.sv
// cam_delta_coder: 1-bit delta coder with saturating reconstruction and partial-word flush
module cam_delta_coder #(
    parameter int PIX_W      = 8,
    parameter int DELTA_STEP = 16
) (
    input  logic             pclk,
    input  logic             reset,
    input  logic             clear,
    input  logic [PIX_W-1:0] pix,
    input  logic             pix_valid,
    input  logic             is_ref,
    input  logic             flush,
    output logic [PIX_W-1:0] word,
    output logic             word_valid,
    output logic             partial
);
    localparam int CW = $clog2(PIX_W);
    localparam logic [PIX_W-1:0] STEP = PIX_W'(DELTA_STEP);
    logic [PIX_W-1:0] last_pixel, sr, step_up, step_dn;
    logic [PIX_W:0]   sum;
    logic [CW-1:0]    bit_cnt;
    logic [CW:0]      sh;
    logic             up;
    always_comb begin
        up = pix > last_pixel;
        sum = {1'b0, last_pixel} + {1'b0, STEP};
        step_up = sum[PIX_W] ? '1 : sum[PIX_W-1:0];
        step_dn = last_pixel >= STEP ? last_pixel - STEP : '0;
        partial = bit_cnt != '0;
        sh = (CW+1)'(PIX_W) - {1'b0, bit_cnt};
        word = flush ? sr << sh : {sr[PIX_W-2:0], up};
        word_valid = flush ? partial : pix_valid && !is_ref && bit_cnt == CW'(PIX_W-1);
    end
    always_ff @(posedge pclk) begin
        if (!reset || clear) begin
            last_pixel <= '0;
            sr <= '0;
            bit_cnt <= '0;
        end else if (flush) begin
            sr <= '0;
            bit_cnt <= '0;
        end else if (pix_valid && is_ref) begin
            last_pixel <= pix;
        end else if (pix_valid) begin
            sr <= {sr[PIX_W-2:0], up};
            last_pixel <= up ? step_up : step_dn;
            bit_cnt <= bit_cnt == CW'(PIX_W-1) ? '0 : bit_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/cam_stream_packer.sv
// cam_stream_packer: packs camera bus beats into framed FIFO words (raw, decimate, delta)
module cam_stream_packer import cam_pkg::*; #(
    parameter int         BUS_W        = 4,
    parameter int         PIX_W        = 8,
    parameter int         N_MARKERS    = 3,
    parameter logic [7:0] START_MARK   = 8'hAA,
    parameter logic [7:0] END_MARK     = 8'h55,
    parameter int         REF_INTERVAL = 33,
    parameter int         DELTA_STEP   = 16
) (
    input  logic             pclk,
    input  logic             reset,
    input  logic [BUS_W-1:0] cam_data,
    input  logic             cam_vsync,
    input  logic             cam_hsync,
    input  logic [2:0]       compress_command,
    input  logic             fifo_full,
    output logic [PIX_W-1:0] output_data,
    output logic             write_en,
    output logic             frame_active,
    output logic             overflow
);
    localparam int NB = PIX_W / BUS_W;
    localparam int BW = NB > 1 ? $clog2(NB) : 1;
    state_t           state;
    logic             vs_q, hs_q, pend, par;
    logic [2:0]       mode, hdr_cnt;
    logic [3:0]       frame_cnt;
    logic [BW-1:0]    beat_cnt, beat_idx;
    logic [PIX_W-1:0] pix_sr, pix, wr_data, d_word;
    logic [7:0]       pix_idx;
    logic fr_start, fr_end, hs_rise, hs_fall, par_eff, pix_done, is_delta, d_valid, d_ref;
    logic d_flush, d_word_valid, d_partial, go_hdr, wr_req, in_frame;
    always_comb begin
        fr_start = cam_vsync & ~vs_q;
        fr_end = ~cam_vsync & vs_q;
        hs_rise = cam_hsync & ~hs_q;
        hs_fall = ~cam_hsync & hs_q;
        beat_idx = hs_rise ? '0 : beat_cnt;
        pix = (pix_sr << BUS_W) | PIX_W'(cam_data);
        in_frame = state == S_HEADER || state == S_ACTIVE || state == S_FLUSH;
        pix_done = state == S_ACTIVE && !fr_end && cam_hsync && beat_idx == BW'(NB-1);
        par_eff = hs_rise ? 1'b0 : par;
        is_delta = mode == MODE_DELTA;
        d_ref = pix_idx == 8'd0;
        d_valid = pix_done && is_delta;
        d_flush = state == S_FLUSH && !fr_end;
        go_hdr = (state == S_IDLE && fr_start) ||
                 (state == S_TRAIL_STAT && cam_vsync && (pend || fr_start));
        wr_req = (state == S_HEADER && !fr_end) || d_flush ||
                 state == S_TRAIL_END || state == S_TRAIL_STAT ||
                 (pix_done && (is_delta ? (d_ref || d_word_valid) : (mode != MODE_DEC || !par_eff)));
        wr_data = state == S_HEADER     ? PIX_W'(START_MARK) :
                  state == S_TRAIL_END  ? PIX_W'(END_MARK) :
                  state == S_TRAIL_STAT ? PIX_W'(status_word(overflow, mode, frame_cnt)) :
                  (is_delta && !(pix_done && d_ref)) ? d_word : pix;
    end
    cam_delta_coder #(.PIX_W(PIX_W), .DELTA_STEP(DELTA_STEP)) u_delta (
        .pclk(pclk), .reset(reset), .clear(go_hdr), .pix(pix), .pix_valid(d_valid),
        .is_ref(d_ref), .flush(d_flush), .word(d_word), .word_valid(d_word_valid),
        .partial(d_partial)
    );
    always_ff @(posedge pclk) begin
        if (!reset) begin
            state <= S_IDLE;
            {vs_q, hs_q, pend, par} <= '0;
            mode <= MODE_RAW;
            hdr_cnt <= '0;
            frame_cnt <= '0;
            beat_cnt <= '0;
            pix_sr <= '0;
            pix_idx <= '0;
            output_data <= '0;
            write_en <= 1'b0;
            frame_active <= 1'b0;
            overflow <= 1'b0;
        end else begin
            vs_q <= cam_vsync;
            hs_q <= cam_hsync;
            write_en <= wr_req && !fifo_full;
            if (wr_req && !fifo_full) output_data <= wr_data;
            if (cam_hsync) begin
                pix_sr <= pix;
                beat_cnt <= beat_idx == BW'(NB-1) ? '0 : beat_idx + 1'b1;
            end
            if (pix_done) par <= ~par_eff;
            else if (hs_rise) par <= 1'b0;
            if (d_valid) pix_idx <= pix_idx == 8'(REF_INTERVAL-1) ? '0 : pix_idx + 1'b1;
            if (state == S_TRAIL_STAT) frame_cnt <= frame_cnt + 1'b1;
            if (go_hdr) begin
                state <= S_HEADER;
                mode <= norm_mode(compress_command);
                overflow <= 1'b0;
                hdr_cnt <= '0;
                beat_cnt <= '0;
                pix_idx <= '0;
                par <= 1'b0;
                pend <= 1'b0;
                frame_active <= 1'b1;
            end else begin
                overflow <= overflow | (wr_req & fifo_full);
                if (in_frame && fr_end) state <= S_TRAIL_END;
                else case (state)
                    S_HEADER: begin
                        hdr_cnt <= hdr_cnt + 1'b1;
                        if (hdr_cnt == 3'(N_MARKERS-1)) state <= S_ACTIVE;
                    end
                    S_ACTIVE: if (hs_fall && is_delta && d_partial) state <= S_FLUSH;
                    S_FLUSH: state <= S_ACTIVE;
                    S_TRAIL_END: begin
                        state <= S_TRAIL_STAT;
                        if (fr_start) pend <= 1'b1;
                    end
                    S_TRAIL_STAT: begin
                        state <= S_IDLE;
                        pend <= 1'b0;
                        frame_active <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
